// File: rtl/dmx_position_slew_if.sv
// Divider-result / DMX-channel bundle for one dmx_position_slew axis.
interface dmx_position_slew_if;
    logic       div_ready;
    logic [7:0] quotient;
    logic [7:0] fractional;
    logic       frame_tick;
    logic [7:0] dmx_coarse;
    logic [7:0] dmx_fine;
    logic       target_valid;
    logic       at_target;
    logic       capture;

    modport master (
        output div_ready, quotient, fractional, frame_tick,
        input  dmx_coarse, dmx_fine, target_valid, at_target, capture
    );

    modport slave (
        input  div_ready, quotient, fractional, frame_tick,
        output dmx_coarse, dmx_fine, target_valid, at_target, capture
    );
endinterface

// File: rtl/dmx_position_slew.sv
// Captures 8.8 divider ratios as a pan/tilt target and slews position toward it once per DMX frame.
// Optional build macro DMX_INVERT_EN mirrors the DMX output bytes for inverted fixture mounting.
module dmx_position_slew #(
    parameter logic [15:0] HOME           = 16'h8000,
    parameter logic [15:0] MIN_POS        = 16'h0000,
    parameter logic [15:0] MAX_POS        = 16'hFFFF,
    parameter logic [15:0] MAX_STEP       = 16'h0400,
    parameter logic [7:0]  TIMEOUT_FRAMES = 8'd22
) (
    input  logic             clk,
    input  logic             reset,
    dmx_position_slew_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

    state_t      state, state_nx;
    logic [15:0] position, position_nx;
    logic [15:0] target, target_nx;
    logic [7:0]  timeout_cnt, cnt_nx;
    logic        div_ready_d, rise, capture_q;
    logic [15:0] raw, clamped;
    logic [16:0] diff;
    logic [15:0] step;
    logic [15:0] out_word, out_q;

`ifdef DMX_INVERT_EN
    localparam logic [15:0] RESET_OUT = 16'hFFFF - HOME;
    assign out_word = 16'hFFFF - position;
`else
    localparam logic [15:0] RESET_OUT = HOME;
    assign out_word = position;
`endif

    assign rise = bus.div_ready & ~div_ready_d;
    assign raw  = {bus.quotient, bus.fractional};

    // Comparisons done at 17 bits so default full-range clamps do not fold to constants.
    always_comb begin
        clamped = raw;
        if (({1'b0, raw} + 17'd1) <= {1'b0, MIN_POS})
            clamped = MIN_POS;
        else if ({1'b0, raw} > {1'b0, MAX_POS})
            clamped = MAX_POS;
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = timeout_cnt;
        target_nx   = target;
        position_nx = position;
        diff        = '0;
        step        = '0;

        // Slew always uses the current target, so a same-cycle capture only affects later frames.
        if (bus.frame_tick) begin
            if (target > position) begin
                diff        = {1'b0, target} - {1'b0, position};
                step        = (diff > {1'b0, MAX_STEP}) ? MAX_STEP : diff[15:0];
                position_nx = position + step;
            end else if (target < position) begin
                diff        = {1'b0, position} - {1'b0, target};
                step        = (diff > {1'b0, MAX_STEP}) ? MAX_STEP : diff[15:0];
                position_nx = position - step;
            end
        end

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = TRACK;
                    cnt_nx   = '0;
                end
            end
            TRACK: begin
                if (rise) begin
                    cnt_nx = '0;
                end else if (timeout_cnt == TIMEOUT_FRAMES) begin
                    state_nx  = LOST;
                    cnt_nx    = '0;
                    target_nx = HOME;
                end else if (bus.frame_tick) begin
                    cnt_nx = timeout_cnt + 8'd1;
                end
            end
            LOST: begin
                cnt_nx    = '0;
                target_nx = HOME;
                if (rise)
                    state_nx = TRACK;
                else if (position == HOME)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (rise)
            target_nx = clamped;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            position    <= HOME;
            target      <= HOME;
            timeout_cnt <= '0;
            div_ready_d <= 1'b0;
            capture_q   <= 1'b0;
            out_q       <= RESET_OUT;
        end else begin
            state       <= state_nx;
            position    <= position_nx;
            target      <= target_nx;
            timeout_cnt <= cnt_nx;
            div_ready_d <= bus.div_ready;
            capture_q   <= rise;
            out_q       <= out_word;
        end
    end

    assign bus.dmx_coarse   = out_q[15:8];
    assign bus.dmx_fine     = out_q[7:0];
    assign bus.capture      = capture_q;
    assign bus.target_valid = (state == TRACK);
    assign bus.at_target    = (position == target);
endmodule
